// File: rtl/ram_pkg.sv
// Shared definitions for the RAM arbiter: state encoding, default sizing
// and the programmer write-buffer entry layout.
package ram_pkg;

  localparam int unsigned DEF_FIFO_DEPTH   = 2;
  localparam int unsigned DEF_MAX_PROG_RUN = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PROG_WR = 3'd1,
    CPU_WR  = 3'd2,
    CPU_RD  = 3'd3,
    RD_WAIT = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } prog_entry_t;

endpackage

// File: rtl/prog_fifo.sv
// Synchronous FIFO for programmer writes. A push while full is accepted only
// when a pop frees the head slot in the same cycle; otherwise it is dropped.
module prog_fifo
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  prog_entry_t push_data,
  input  logic        pop,
  output prog_entry_t pop_data,
  output logic        full,
  output logic        empty,
  output logic        drop
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  prog_entry_t      mem_q [DEPTH];
  prog_entry_t      mem_d [DEPTH];
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    drop     = push & ~do_push;
    pop_data = mem_q[rd_ptr_q];
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the empty count masks stale contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between a buffered programmer write stream and a
// CPU request/grant port, with bounded programmer bursts while the CPU waits.
//
// state   | meaning
// IDLE    | no RAM access this cycle
// PROG_WR | writing the popped programmer entry
// CPU_WR  | writing CPU data, grant asserted
// CPU_RD  | RAM read address driven, grant asserted
// RD_WAIT | RAM read data returned to the CPU
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int unsigned MAX_PROG_RUN = DEF_MAX_PROG_RUN
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        progWrEn,
  input  logic [7:0]  progAddr,
  input  logic [15:0] progData,
  input  logic        progMode,
  output logic        progOvf,
  input  logic        cpuReq,
  input  logic        cpuWe,
  input  logic [7:0]  cpuAddr,
  input  logic [15:0] cpuWData,
  output logic        cpuGnt,
  output logic [15:0] cpuRData,
  output logic        cpuRValid,
  output logic        ramWe,
  output logic [7:0]  ramAddr,
  output logic [15:0] ramWData,
  input  logic [15:0] ramRData
);

  arb_state_e  state_q, state_d;
  logic [2:0]  prog_run_q, prog_run_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  ram_addr_q, ram_addr_d;
  logic [15:0] ram_wdata_q, ram_wdata_d;

  prog_entry_t fifo_head;
  logic        fifo_pop, fifo_empty, fifo_full, fifo_drop;
  logic        cpu_gnt, cpu_eligible, run_at_max, cpu_grant_next;

  prog_fifo #(.DEPTH(FIFO_DEPTH)) u_prog_fifo (
    .clk      (clk),
    .rst_n    (rstN),
    .push     (progWrEn),
    .push_data({progAddr, progData}),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .drop     (fifo_drop)
  );

  always_comb begin
    cpu_gnt = (state_q == CPU_WR) || (state_q == CPU_RD);
    // While the grant is showing, cpuReq still carries the consumed request.
    cpu_eligible   = cpuReq & ~progMode & ~cpu_gnt;
    run_at_max     = (prog_run_q == 3'(MAX_PROG_RUN));
    state_d        = IDLE;
    fifo_pop       = 1'b0;
    cpu_grant_next = 1'b0;
    ram_addr_d     = ram_addr_q;
    ram_wdata_d    = ram_wdata_q;
    ovf_d          = ovf_q | fifo_drop;

    if (state_q == CPU_RD) begin
      state_d = RD_WAIT;
    end else if (!fifo_empty && !(cpu_eligible && run_at_max)) begin
      state_d     = PROG_WR;
      fifo_pop    = 1'b1;
      ram_addr_d  = fifo_head.addr;
      ram_wdata_d = fifo_head.data;
    end else if (cpu_eligible) begin
      state_d        = cpuWe ? CPU_WR : CPU_RD;
      cpu_grant_next = 1'b1;
      ram_addr_d     = cpuAddr;
      if (cpuWe) ram_wdata_d = cpuWData;
    end

    prog_run_d = prog_run_q;
    if (!cpu_eligible || cpu_grant_next) begin
      prog_run_d = '0;
    end else if (state_d == PROG_WR && !run_at_max) begin
      prog_run_d = prog_run_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      prog_run_q  <= '0;
      ovf_q       <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      prog_run_q  <= prog_run_d;
      ovf_q       <= ovf_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign ramWe     = (state_q == PROG_WR) || (state_q == CPU_WR);
  assign ramAddr   = ram_addr_q;
  assign ramWData  = ram_wdata_q;
  assign cpuGnt    = cpu_gnt;
  assign cpuRValid = (state_q == RD_WAIT);
  assign cpuRData  = cpuRValid ? ramRData : '0;
  assign progOvf   = ovf_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a vector table of single transactions plus
// hand-written multi-cycle sequences, against a behavioural RAM model.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic        progWrEn;
  logic [7:0]  progAddr;
  logic [15:0] progData;
  logic        progMode;
  logic        progOvf;
  logic        cpuReq;
  logic        cpuWe;
  logic [7:0]  cpuAddr;
  logic [15:0] cpuWData;
  logic        cpuGnt;
  logic [15:0] cpuRData;
  logic        cpuRValid;
  logic        ramWe;
  logic [7:0]  ramAddr;
  logic [15:0] ramWData;
  logic [15:0] ramRData;

  int n_chk  = 0;
  int n_fail = 0;

  ram_arbiter dut (
    .clk      (clk),
    .rstN     (rstN),
    .progWrEn (progWrEn),
    .progAddr (progAddr),
    .progData (progData),
    .progMode (progMode),
    .progOvf  (progOvf),
    .cpuReq   (cpuReq),
    .cpuWe    (cpuWe),
    .cpuAddr  (cpuAddr),
    .cpuWData (cpuWData),
    .cpuGnt   (cpuGnt),
    .cpuRData (cpuRData),
    .cpuRValid(cpuRValid),
    .ramWe    (ramWe),
    .ramAddr  (ramAddr),
    .ramWData (ramWData),
    .ramRData (ramRData)
  );

  always #5 clk = ~clk;

  // RAM model with one-cycle read latency, plus a log of programmer writes.
  logic [15:0] mem [256];
  int          prog_wr_cnt = 0;
  logic [15:0] last_prog_data = '0;

  always @(posedge clk) begin
    if (ramWe) mem[ramAddr] <= ramWData;
    ramRData <= mem[ramAddr];
    if (rstN && ramWe && !cpuGnt) begin
      prog_wr_cnt    <= prog_wr_cnt + 1;
      last_prog_data <= ramWData;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        mode;
    logic        is_cpu;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        exp_gnt;
    logic        exp_we;
    logic [7:0]  exp_addr;
    logic        chk_wdata;
    logic [15:0] exp_wdata;
    logic        exp_rvalid;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic run_vec(input vec_t v);
    progMode = v.mode;
    if (!v.is_cpu) begin
      progWrEn = 1'b1;
      progAddr = v.addr;
      progData = v.data;
      tick();
      progWrEn = 1'b0;
      tick();
    end else begin
      cpuReq   = 1'b1;
      cpuWe    = v.we;
      cpuAddr  = v.addr;
      cpuWData = v.data;
      tick();
    end
    chk("vec_gnt", cpuGnt, v.exp_gnt);
    chk("vec_ramwe", ramWe, v.exp_we);
    chk("vec_ramaddr", ramAddr, v.exp_addr);
    if (v.chk_wdata) chk("vec_ramwdata", ramWData, v.exp_wdata);
    if (v.is_cpu && !v.exp_gnt) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("vec_blocked_gnt", cpuGnt, 1'b0);
      end
    end
    cpuReq = 1'b0;
    tick();
    chk("vec_rvalid", cpuRValid, v.exp_rvalid);
    if (v.exp_rvalid) chk("vec_rdata", cpuRData, v.exp_rdata);
    progMode = 1'b0;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ramwe"}, ramWe, 1'b0);
    chk({tag, "_ramaddr"}, ramAddr, 8'h00);
    chk({tag, "_ramwdata"}, ramWData, 16'h0000);
    chk({tag, "_gnt"}, cpuGnt, 1'b0);
    chk({tag, "_rvalid"}, cpuRValid, 1'b0);
    chk({tag, "_rdata"}, cpuRData, 16'h0000);
    chk({tag, "_ovf"}, progOvf, 1'b0);
  endtask

  // Programmer pulses every cycle while a CPU request is held; returns the
  // number of programmer writes seen before the grant.
  task automatic starve_run(input logic we, input int n_pulses,
                            output int streak, output logic gnt_seen);
    streak   = 0;
    gnt_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      progWrEn = (i < n_pulses);
      progAddr = 8'h40 + 8'(i);
      progData = 16'h2000 + 16'(i);
      cpuReq   = (i >= 1) && !gnt_seen;
      cpuWe    = we;
      cpuAddr  = 8'h60;
      cpuWData = 16'hBEEF;
      tick();
      if (cpuGnt && !gnt_seen) gnt_seen = 1'b1;
      else if (ramWe && !gnt_seen) streak++;
    end
    progWrEn = 1'b0;
    cpuReq   = 1'b0;
  endtask

  initial begin
    int   base_cnt;
    int   streak;
    logic gnt_seen;
    int   bad;

    vecs[0]  = '{1, 0, 0, 8'h05, 16'hABCD, 0, 1, 8'h05, 1, 16'hABCD, 0, 16'h0000};
    vecs[1]  = '{0, 0, 0, 8'h10, 16'h1234, 0, 1, 8'h10, 1, 16'h1234, 0, 16'h0000};
    vecs[2]  = '{0, 1, 0, 8'h10, 16'h0000, 1, 0, 8'h10, 0, 16'h0000, 1, 16'h1234};
    vecs[3]  = '{0, 1, 1, 8'h30, 16'h5A5A, 1, 1, 8'h30, 1, 16'h5A5A, 0, 16'h0000};
    vecs[4]  = '{0, 1, 0, 8'h30, 16'h0000, 1, 0, 8'h30, 0, 16'h0000, 1, 16'h5A5A};
    vecs[5]  = '{1, 1, 0, 8'h05, 16'h0000, 0, 0, 8'h30, 1, 16'h5A5A, 0, 16'h0000};
    vecs[6]  = '{0, 1, 0, 8'h05, 16'h0000, 1, 0, 8'h05, 0, 16'h0000, 1, 16'hABCD};
    vecs[7]  = '{0, 1, 1, 8'h05, 16'h0000, 1, 1, 8'h05, 1, 16'h0000, 0, 16'h0000};
    vecs[8]  = '{0, 1, 0, 8'h05, 16'h0000, 1, 0, 8'h05, 0, 16'h0000, 1, 16'h0000};
    vecs[9]  = '{0, 0, 0, 8'hFF, 16'hC3C3, 0, 1, 8'hFF, 1, 16'hC3C3, 0, 16'h0000};
    vecs[10] = '{0, 1, 0, 8'hFF, 16'h0000, 1, 0, 8'hFF, 0, 16'h0000, 1, 16'hC3C3};

    rstN = 1'b0; progWrEn = 1'b0; progAddr = '0; progData = '0; progMode = 1'b0;
    cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWData = '0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Three back-to-back pulses through a two-entry buffer.
    for (int i = 0; i < 5; i++) begin
      progWrEn = (i < 3);
      progAddr = 8'h50 + 8'(i);
      progData = 16'h3000 + 16'(i);
      tick();
      chk("burst3_ramwe", ramWe, (i >= 1 && i <= 3));
      if (i >= 1 && i <= 3) begin
        chk("burst3_addr", ramAddr, 8'h50 + 8'(i - 1));
        chk("burst3_data", ramWData, 16'h3000 + 16'(i - 1));
      end
    end
    chk("burst3_ovf", progOvf, 1'b0);
    repeat (2) tick();

    // CPU write arriving while a programmer entry sits at the head.
    progWrEn = 1'b1; progAddr = 8'h21; progData = 16'h1111;
    tick();
    progWrEn = 1'b0;
    cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 8'h20; cpuWData = 16'h0077;
    tick();
    chk("order_prog_we", ramWe, 1'b1);
    chk("order_prog_gnt", cpuGnt, 1'b0);
    chk("order_prog_addr", ramAddr, 8'h21);
    tick();
    chk("order_cpu_gnt", cpuGnt, 1'b1);
    chk("order_cpu_we", ramWe, 1'b1);
    chk("order_cpu_addr", ramAddr, 8'h20);
    chk("order_cpu_data", ramWData, 16'h0077);
    cpuReq = 1'b0;
    repeat (3) tick();

    // Starvation bound with a CPU write; full buffer with simultaneous pop.
    base_cnt = prog_wr_cnt;
    starve_run(1'b1, 8, streak, gnt_seen);
    chk("starve_wr_gnt", gnt_seen, 1'b1);
    chk("starve_wr_streak", streak, 4);
    chk("starve_wr_count", prog_wr_cnt - base_cnt, 8);
    chk("starve_wr_last", last_prog_data, 16'h2007);
    chk("starve_wr_ovf", progOvf, 1'b0);

    // Same with a CPU read: two no-pop cycles fill the buffer and drop one.
    base_cnt = prog_wr_cnt;
    starve_run(1'b0, 7, streak, gnt_seen);
    chk("starve_rd_gnt", gnt_seen, 1'b1);
    chk("starve_rd_streak", streak, 4);
    chk("starve_rd_count", prog_wr_cnt - base_cnt, 6);
    chk("starve_rd_last", last_prog_data, 16'h2005);
    chk("starve_rd_ovf", progOvf, 1'b1);
    repeat (3) tick();
    chk("ovf_sticky", progOvf, 1'b1);

    // Reset while a read is in flight and a programmer entry is buffered.
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 8'h10;
    progWrEn = 1'b1; progAddr = 8'h77; progData = 16'h7777;
    tick();
    chk("rst_rd_gnt", cpuGnt, 1'b1);
    cpuReq = 1'b0; progWrEn = 1'b0;
    tick();
    chk("rst_rd_rvalid", cpuRValid, 1'b1);
    #2;
    rstN = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    base_cnt = prog_wr_cnt;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpuRValid || ramWe) bad++;
    end
    chk("postrst_quiet", bad, 0);
    chk("postrst_no_prog", prog_wr_cnt - base_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
